// File: rtl/counter_64_bit_ctrl.sv
// counter_64_bit_ctrl
// This block arbitrates between two requesters and sequences commands onto a
// 64-bit counter. A command is either a load or a burst increment of N.
//
// Handshake: reqX_valid/reqX_data/reqX_load are held by the requester until
// it sees reqX_ready. reqX_ready is combinational. It is high only in IDLE
// with rst low, and only for the single arbitration winner. The command
// transfers on the clock edge that ends a cycle where valid and ready are
// both high.
//
// Optional build macro: COUNTER_CTRL_RR_EN.
//   Defined:   round-robin arbitration.
//   Undefined: fixed priority, with requester 0 winning.
// All outputs except the readys are registered. They are updated in the
// same always_ff as the state, so busy always equals (state != IDLE).
module counter_64_bit_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic        req0_load,
    input  logic [63:0] req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic        req1_load,
    input  logic [63:0] req1_data,
    output logic        req1_ready,
    output logic        cnt_wen,
    output logic        cnt_load,
    output logic [63:0] cnt_din,
    output logic        busy,
    output logic        done,
    output logic        done_id
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        BURST = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state;
    // Holds the accepted operand. In BURST it counts down the remaining
    // increments. The opcode is captured by the state that the accept
    // selects, so it needs no separate register.
    logic [63:0] remaining;
    logic        lat_id;

    logic        any_valid;
    logic        accept;
    logic        grant_id;
    logic        sel_load;
    logic [63:0] sel_data;

`ifdef COUNTER_CTRL_RR_EN
    logic        last_grant;

    // Round-robin: on a tie, the requester that did not win last time wins.
    always_comb begin
        grant_id = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_id = ~last_grant;
        end else if (req1_valid) begin
            grant_id = 1'b1;
        end
    end
`else
    // Fixed priority: requester 0 wins whenever it is valid.
    always_comb begin
        grant_id = 1'b0;
        if (!req0_valid && req1_valid) begin
            grant_id = 1'b1;
        end
    end
`endif

    // Accept only in IDLE and never while reset is asserted.
    // Then steer the winner's command onto the select path.
    always_comb begin
        any_valid  = req0_valid | req1_valid;
        accept     = (state == IDLE) && !rst && any_valid;
        req0_ready = accept && !grant_id;
        req1_ready = accept && grant_id;
        sel_load   = grant_id ? req1_load : req0_load;
        sel_data   = grant_id ? req1_data : req0_data;
    end

    // Command FSM, with every counter-facing output registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            remaining <= 64'd0;
            lat_id    <= 1'b0;
            cnt_wen   <= 1'b0;
            cnt_load  <= 1'b0;
            cnt_din   <= 64'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            done_id   <= 1'b0;
`ifdef COUNTER_CTRL_RR_EN
            last_grant <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        lat_id    <= grant_id;
                        remaining <= sel_data;
                        busy      <= 1'b1;
`ifdef COUNTER_CTRL_RR_EN
                        last_grant <= grant_id;
`endif
                        if (sel_load) begin
                            state    <= LOAD;
                            cnt_load <= 1'b1;
                            cnt_din  <= sel_data;
                        end else if (sel_data != 64'd0) begin
                            state   <= BURST;
                            cnt_wen <= 1'b1;
                        end else begin
                            // A zero-length burst goes straight to completion.
                            state   <= DONE;
                            done    <= 1'b1;
                            done_id <= grant_id;
                        end
                    end
                end
                LOAD: begin
                    state     <= DONE;
                    cnt_load  <= 1'b0;
                    cnt_din   <= 64'd0;
                    remaining <= 64'd0;
                    done      <= 1'b1;
                    done_id   <= lat_id;
                end
                BURST: begin
                    remaining <= remaining - 64'd1;
                    if (remaining == 64'd1) begin
                        state   <= DONE;
                        cnt_wen <= 1'b0;
                        done    <= 1'b1;
                        done_id <= lat_id;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    done    <= 1'b0;
                    done_id <= 1'b0;
                    busy    <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    cnt_wen  <= 1'b0;
                    cnt_load <= 1'b0;
                    cnt_din  <= 64'd0;
                    done     <= 1'b0;
                    done_id  <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter_64_bit_ctrl.sv
// tb_counter_64_bit_ctrl
// Directed bench for counter_64_bit_ctrl. It models the downstream 64-bit
// counter so that load and burst effects can be compared against hand-computed
// values. Inputs change 1 time unit after posedge. Outputs are inspected 2
// time units after posedge.
module tb_counter_64_bit_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_load, req1_valid, req1_load;
    logic [63:0] req0_data, req1_data;
    logic        req0_ready, req1_ready;
    logic        cnt_wen, cnt_load, busy, done, done_id;
    logic [63:0] cnt_din;

    logic [63:0] ctr = 64'd0;
    int          checks = 0;
    int          fails = 0;

    localparam logic [63:0] LOAD_D = 64'hDEADBEEFCAFEBABE;

    counter_64_bit_ctrl dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_load(req0_load), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_load(req1_load), .req1_data(req1_data), .req1_ready(req1_ready),
        .cnt_wen(cnt_wen), .cnt_load(cnt_load), .cnt_din(cnt_din),
        .busy(busy), .done(done), .done_id(done_id)
    );

    // Clock generation.
    always #5 clk = ~clk;

    // Downstream counter model. It is not reset, so an aborted burst stays visible.
    always @(posedge clk) begin
        if (cnt_load) ctr <= cnt_din;
        else if (cnt_wen) ctr <= ctr + 64'd1;
    end

    // Structural properties checked on every clock edge.
    a_ready_onehot0: assert property (@(posedge clk) $onehot0({req1_ready, req0_ready}))
        else $error("FAIL sva_ready_onehot0");
    a_wen_load_excl: assert property (@(posedge clk) !(cnt_wen && cnt_load))
        else $error("FAIL sva_wen_load_exclusive");
    a_done_busy: assert property (@(posedge clk) disable iff (rst) done |-> busy)
        else $error("FAIL sva_done_not_idle");
    a_din_zero: assert property (@(posedge clk) !cnt_load |-> (cnt_din == 64'd0))
        else $error("FAIL sva_din_zero");
    a_rst_ready: assert property (@(posedge clk) rst |-> !(req0_ready || req1_ready))
        else $error("FAIL sva_ready_in_reset");
    c_done_id1: cover property (@(posedge clk) done && done_id);

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0; req0_load = 1'b0; req0_data = 64'd0;
        req1_valid = 1'b0; req1_load = 1'b0; req1_data = 64'd0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1; req0_load = 1'b1; req1_load = 1'b1;
        step(); step();
        #1;
        checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b%b required 00", req1_ready, req0_ready); end
        checks++; if ({cnt_wen, cnt_load, busy, done, done_id} !== 5'b0) begin fails++; $display("FAIL reset_outputs: got %b required 00000", {cnt_wen, cnt_load, busy, done, done_id}); end
        checks++; if (cnt_din !== 64'd0) begin fails++; $display("FAIL reset_din: got %h required 0", cnt_din); end
        rst = 1'b0;
        idle_inputs();
        step();
        #1;
        checks++; if (busy !== 1'b0 || req0_ready !== 1'b0) begin fails++; $display("FAIL reset_idle: busy %b ready0 %b required 0 0", busy, req0_ready); end
    endtask

    task automatic test_load();
        req0_valid = 1'b1; req0_load = 1'b1; req0_data = LOAD_D;
        #1;
        checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin fails++; $display("FAIL load_accept: got %b%b required 01", req1_ready, req0_ready); end
        step();
        idle_inputs();
        // A request raised during a busy state must be ignored.
        req1_valid = 1'b1; req1_load = 1'b1; req1_data = 64'h1234;
        #1;
        checks++; if (cnt_load !== 1'b1 || cnt_din !== LOAD_D) begin fails++; $display("FAIL load_strobe: cnt_load %b din %h required 1 %h", cnt_load, cnt_din, LOAD_D); end
        checks++; if (cnt_wen !== 1'b0 || busy !== 1'b1 || done !== 1'b0 || req1_ready !== 1'b0) begin fails++; $display("FAIL load_t1_ctrl: wen %b busy %b done %b ready1 %b required 0 1 0 0", cnt_wen, busy, done, req1_ready); end
        step();
        #1;
        checks++; if (done !== 1'b1 || done_id !== 1'b0) begin fails++; $display("FAIL load_done: done %b id %b required 1 0", done, done_id); end
        checks++; if (cnt_load !== 1'b0 || cnt_din !== 64'd0 || req1_ready !== 1'b0) begin fails++; $display("FAIL load_t2_ctrl: load %b din %h ready1 %b required 0 0 0", cnt_load, cnt_din, req1_ready); end
        idle_inputs();
        step();
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL load_idle: busy %b done %b required 0 0", busy, done); end
        checks++; if (ctr !== LOAD_D) begin fails++; $display("FAIL load_counter: got %h required %h", ctr, LOAD_D); end
    endtask

    task automatic test_burst();
        logic [63:0] base;
        base = ctr;
        req1_valid = 1'b1; req1_load = 1'b0; req1_data = 64'd3;
        #1;
        checks++; if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin fails++; $display("FAIL burst_accept: got %b%b required 10", req1_ready, req0_ready); end
        step();
        idle_inputs();
        for (int i = 1; i <= 3; i++) begin
            #1;
            checks++; if (cnt_wen !== 1'b1 || done !== 1'b0 || cnt_load !== 1'b0) begin fails++; $display("FAIL burst_wen_t%0d: wen %b done %b load %b required 1 0 0", i, cnt_wen, done, cnt_load); end
            step();
        end
        #1;
        checks++; if (done !== 1'b1 || done_id !== 1'b1 || cnt_wen !== 1'b0) begin fails++; $display("FAIL burst_done: done %b id %b wen %b required 1 1 0", done, done_id, cnt_wen); end
        step();
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL burst_idle: busy %b done %b required 0 0", busy, done); end
        checks++; if (ctr !== base + 64'd3) begin fails++; $display("FAIL burst_counter: got %h required %h", ctr, base + 64'd3); end
    endtask

    task automatic test_burst_zero();
        logic [63:0] base;
        base = ctr;
        req0_valid = 1'b1; req0_load = 1'b0; req0_data = 64'd0;
        #1;
        checks++; if (req0_ready !== 1'b1) begin fails++; $display("FAIL zero_accept: got %b required 1", req0_ready); end
        step();
        idle_inputs();
        #1;
        checks++; if (done !== 1'b1 || done_id !== 1'b0 || cnt_wen !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL zero_done: done %b id %b wen %b busy %b required 1 0 0 1", done, done_id, cnt_wen, busy); end
        step();
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0 || cnt_wen !== 1'b0) begin fails++; $display("FAIL zero_idle: busy %b done %b wen %b required 0 0 0", busy, done, cnt_wen); end
        checks++; if (ctr !== base) begin fails++; $display("FAIL zero_counter: got %h required %h", ctr, base); end
    endtask

    task automatic test_arbitration();
        logic got;
        logic exp_grant;
        rst = 1'b1;
        step();
        rst = 1'b0;
        req0_valid = 1'b1; req0_load = 1'b1; req0_data = 64'hA0;
        req1_valid = 1'b1; req1_load = 1'b1; req1_data = 64'hB1;
        for (int k = 0; k < 4; k++) begin
            got = 1'b0;
            for (int c = 0; c < 8 && !got; c++) begin
                #1;
                if (req0_ready || req1_ready) begin
                    got = 1'b1;
`ifdef COUNTER_CTRL_RR_EN
                    exp_grant = k[0];
`else
                    exp_grant = 1'b0;
`endif
                    checks++; if ({req1_ready, req0_ready} !== (exp_grant ? 2'b10 : 2'b01)) begin fails++; $display("FAIL arb_grant_%0d: got %b%b required grant %0d", k, req1_ready, req0_ready, exp_grant); end
                end
                step();
            end
            if (!got) begin
                checks++; fails++;
                $display("FAIL arb_timeout_%0d: no ready within 8 cycles, required a grant", k);
            end
        end
        idle_inputs();
        step(); step(); step();
    endtask

    task automatic test_reset_mid_burst();
        logic [63:0] base;
        base = ctr;
        req0_valid = 1'b1; req0_load = 1'b0; req0_data = 64'd100;
        #1;
        checks++; if (req0_ready !== 1'b1) begin fails++; $display("FAIL abort_accept: got %b required 1", req0_ready); end
        step();
        idle_inputs();
        for (int i = 1; i < 10; i++) step();
        #1;
        checks++; if (cnt_wen !== 1'b1 || busy !== 1'b1) begin fails++; $display("FAIL abort_pre: wen %b busy %b required 1 1", cnt_wen, busy); end
        rst = 1'b1;
        step();
        #1;
        checks++; if (cnt_wen !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL abort_post: wen %b busy %b done %b required 0 0 0", cnt_wen, busy, done); end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            #1;
            checks++; if (done !== 1'b0 || cnt_wen !== 1'b0) begin fails++; $display("FAIL abort_quiet_%0d: done %b wen %b required 0 0", i, done, cnt_wen); end
        end
        checks++; if (ctr !== base + 64'd10) begin fails++; $display("FAIL abort_counter: got %h required %h", ctr, base + 64'd10); end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        #1;
        test_reset();
        test_load();
        test_burst();
        test_burst_zero();
        test_arbitration();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
